register_file_mp: RTL and testbench
===================================

Name: register_file_mp

Overview:
- Multi-port architectural register file plus rename/dependency table.
- Sits between the Dispatcher (up to DP_PORTS instructions per cycle, in program order) and the RoB commit stage (up to CMT_PORTS retirements per cycle, in program order).
- Returns operand tags and values with intra-bundle and same-cycle-commit forwarding.
- Runs a one-cycle flush-recovery state after a misprediction.

Parameters:
- REG_WIDTH, 5, architectural register index width; EX_REG_WIDTH = REG_WIDTH+1; NON_REG = 1<<REG_WIDTH.
- ROB_WIDTH, 8, RoB index width; EX_ROB_WIDTH = ROB_WIDTH+1; NON_DEP = 1<<ROB_WIDTH.
- DP_PORTS, 2, dispatch lanes per cycle (lane 0 oldest).
- CMT_PORTS, 2, commit lanes per cycle (lane 0 oldest).

Ports:
- Sys_clk  in  1  clock. One clock; every state element is clocked on its rising edge.
- Sys_rst_n  in  1  reset; asynchronous, active-low.
- Sys_rdy  in  1  global enable; when 0, all state holds.
- DPRF_en  in  DP_PORTS  per-lane dispatch valid.
- DPRF_rs1, DPRF_rs2, DPRF_rd  in  DP_PORTS*EX_REG_WIDTH  packed lane operands; NON_REG means none.
- DPRF_RoB_index  in  DP_PORTS*ROB_WIDTH  RoB slot of each lane's destination.
- RFDP_Qj, RFDP_Qk  out  DP_PORTS*EX_ROB_WIDTH  operand tags; NON_DEP means the value is ready.
- RFDP_Vj, RFDP_Vk  out  DP_PORTS*32  operand values; valid only when the matching Q equals NON_DEP.
- RFDP_ready  out  1  dispatch accepted this cycle.
- RoBRF_flush  in  1  misprediction; instantaneous, active-high.
- RoBRF_en  in  CMT_PORTS  per-lane commit valid.
- RoBRF_rd  in  CMT_PORTS*EX_REG_WIDTH  commit destination; NON_REG means none.
- RoBRF_RoB_index  in  CMT_PORTS*ROB_WIDTH  committing RoB slot.
- RoBRF_value  in  CMT_PORTS*32  commit result.

Behaviour:
Reset (Sys_rst_n=0, asynchronous):
- All registers 0.
- All dependency entries NON_DEP.
- State goes to RUN, RFDP_ready=1.
- Reset in FLUSH abandons recovery.

State machine:
- RUN: RFDP_ready=1. RoBRF_flush & Sys_rdy -> FLUSH.
- FLUSH: RFDP_ready=0; DPRF_en ignored. Next Sys_rdy edge -> RUN.
- Flush arriving while in FLUSH stays in FLUSH.

Lookup, combinational, per lane k and per source rs:
- Priority 1: rs==NON_REG -> Q=NON_DEP, V=0.
- Priority 2: the youngest lane j<k with DPRF_en[j] and DPRF_rd[j]==rs -> Q=DPRF_RoB_index[j], V=0. This applies even if lane k itself is not enabled.
- Priority 3: dep[rs] equals RoBRF_RoB_index[c] with RoBRF_en[c] -> Q=NON_DEP, V=RoBRF_value[c]. RoB indices are unique, so at most one lane matches.
- Priority 4: dep[rs]==NON_DEP -> Q=NON_DEP, V=registers[rs].
- Otherwise: Q=dep[rs], V=0.
- RoBRF_flush=1 or state FLUSH forces all Q to NON_DEP.

Commit (posedge, Sys_rdy=1):
- For each enabled lane with rd!=NON_REG, registers[rd] <= value.
- Same-rd conflicts: the highest (youngest) commit lane wins.
- dep[rd] <= NON_DEP when all three hold:
  - the pre-edge dep[rd] equals that lane's index;
  - no accepted dispatch lane writes rd this cycle;
  - no flush.
- Commits are performed during flush and during FLUSH state.

Dispatch (posedge, Sys_rdy=1, state RUN, no flush):
- For each enabled lane with rd!=NON_REG, dep[rd] <= index.
- The youngest lane wins.
- Dispatch overrides commit clearing.

Flush:
- All dep <= NON_DEP at the edge.
- Register writes from the same-cycle commit still occur.

Sys_rdy=0: no register, dep or state update; lookup outputs remain live.

Optional Feature:
- Macro: RF_ZERO_REG_EN.
- Defined: register 0 is hardwired.
  - Commits to rd=0 are dropped.
  - dep[0] is never set.
  - Lookups of rs=0 return Q=NON_DEP, V=0 and skip intra-bundle matching against rd=0.
- Undefined: register 0 behaves like any other register.

Decomposition:
- Shared package rf_pkg:
  - REG_WIDTH, EX_REG_WIDTH, NON_REG;
  - ROB_WIDTH, EX_ROB_WIDTH, NON_DEP;
  - state enum {RUN, FLUSH}.
- Sub-module rf_operand_lookup: one instance per source per lane (2*DP_PORTS). It is parametrised by lane position k and implements the lookup priority chain.

Test Plan:
- Reset, then dispatch lane0 rs1=3 -> Qj=NON_DEP, Vj=0, RFDP_ready=1.
- Single-lane commit/forward:
  - Cycle 1: lane0 dispatch rd=5, RoB=7.
  - Cycle 2: lane0 rs1=5 -> Qj=7.
  - Cycle 3: commit rd=5, idx=7, value=0xAB while lane0 rs1=5 -> Qj=NON_DEP, Vj=0xAB.
  - Cycle 4: rs1=5 -> Vj=0xAB from the register.
- Intra-bundle: lane0 rd=4, idx=9; lane1 rs2=4 -> lane1 Qk=9. Next cycle dep[4]=9.
- Same-rd conflicts: lane0 rd=6, idx=10; lane1 rd=6, idx=11 -> dep[6]=11. Commit lanes 0 and 1 both rd=2 with values 1 and 2 -> reg2=2.
- Commit/dispatch collision: commit rd=8, idx=3 while dep[8]=3 and lane0 dispatches rd=8, idx=12 -> dep[8]=12, reg8 updated.
- Flush:
  - Set dep[1]=20, then assert RoBRF_flush with commit rd=9, value=5.
  - That cycle: Q outputs all NON_DEP.
  - Next cycle: RFDP_ready=0 and a dispatch of rd=1 is ignored; reg9=5.
  - Following cycle: ready=1, dep[1]=NON_DEP.
  - Under RF_ZERO_REG_EN: commit rd=0, value=7 -> rs=0 reads V=0.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared widths, sentinels and state encoding for register_file_mp.
// RF_ZERO_REG_EN: when defined, architectural register 0 is hardwired to zero.
package rf_pkg;

    localparam int REG_WIDTH    = 5;
    localparam int EX_REG_WIDTH = REG_WIDTH + 1;
    localparam int NUM_REGS     = 1 << REG_WIDTH;
    localparam logic [EX_REG_WIDTH-1:0] NON_REG =
        {1'b1, {REG_WIDTH{1'b0}}};

    localparam int ROB_WIDTH    = 8;
    localparam int EX_ROB_WIDTH = ROB_WIDTH + 1;
    localparam logic [EX_ROB_WIDTH-1:0] NON_DEP =
        {1'b1, {ROB_WIDTH{1'b0}}};

`ifdef RF_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    typedef enum logic {RUN, FLUSH} rf_state_e;

    // A name that refers to real, writable state (excludes NON_REG and a hardwired r0).
    function automatic logic is_reg(input logic [EX_REG_WIDTH-1:0] r);
        return !r[REG_WIDTH] && !(ZERO_REG && r[REG_WIDTH-1:0] == '0);
    endfunction

endpackage

// File: rtl/rf_operand_lookup.sv
// Resolves one source operand of dispatch lane K to a tag or a value.
// Priority: no-reg, older lane in bundle, same-cycle commit, register, dep tag.
module rf_operand_lookup
    import rf_pkg::*;
#(
    parameter int K         = 0,
    parameter int DP_PORTS  = 2,
    parameter int CMT_PORTS = 2
) (
    input  logic [EX_REG_WIDTH-1:0]          rs,
    input  logic                             flush_any,
    input  logic [DP_PORTS-1:0]              dp_en,
    input  logic [DP_PORTS*EX_REG_WIDTH-1:0] dp_rd,
    input  logic [DP_PORTS*ROB_WIDTH-1:0]    dp_index,
    input  logic [CMT_PORTS-1:0]             cmt_en,
    input  logic [CMT_PORTS*ROB_WIDTH-1:0]   cmt_index,
    input  logic [CMT_PORTS*32-1:0]          cmt_value,
    input  logic [EX_ROB_WIDTH-1:0]          dep,
    input  logic [31:0]                      reg_value,
    output logic [EX_ROB_WIDTH-1:0]          q,
    output logic [31:0]                      v
);

    logic                 fwd_hit;
    logic [ROB_WIDTH-1:0] fwd_tag;
    logic                 cmt_hit;
    logic [31:0]          cmt_val;

    always_comb begin
        fwd_hit = 1'b0;
        fwd_tag = '0;
        for (int j = 0; j < DP_PORTS; j++) begin
            if (j < K && dp_en[j] &&
                dp_rd[j*EX_REG_WIDTH +: EX_REG_WIDTH] == rs) begin
                fwd_hit = 1'b1;
                fwd_tag = dp_index[j*ROB_WIDTH +: ROB_WIDTH];
            end
        end
        cmt_hit = 1'b0;
        cmt_val = '0;
        for (int c = 0; c < CMT_PORTS; c++) begin
            if (cmt_en[c] &&
                dep == {1'b0, cmt_index[c*ROB_WIDTH +: ROB_WIDTH]}) begin
                cmt_hit = 1'b1;
                cmt_val = cmt_value[c*32 +: 32];
            end
        end
    end

    always_comb begin
        q = NON_DEP;
        v = '0;
        if (is_reg(rs)) begin
            if (fwd_hit) begin
                q = {1'b0, fwd_tag};
            end else if (cmt_hit) begin
                v = cmt_val;
            end else if (dep == NON_DEP) begin
                v = reg_value;
            end else begin
                q = dep;
            end
        end
        if (flush_any) begin
            q = NON_DEP;
        end
    end

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file with rename table, bundle/commit forwarding and flush recovery.
// RF_ZERO_REG_EN: when defined, register 0 is hardwired to zero.
module register_file_mp
    import rf_pkg::*;
#(
    parameter int DP_PORTS  = 2,
    parameter int CMT_PORTS = 2
) (
    input  logic                             Sys_clk,
    input  logic                             Sys_rst_n,
    input  logic                             Sys_rdy,
    input  logic [DP_PORTS-1:0]              DPRF_en,
    input  logic [DP_PORTS*EX_REG_WIDTH-1:0] DPRF_rs1,
    input  logic [DP_PORTS*EX_REG_WIDTH-1:0] DPRF_rs2,
    input  logic [DP_PORTS*EX_REG_WIDTH-1:0] DPRF_rd,
    input  logic [DP_PORTS*ROB_WIDTH-1:0]    DPRF_RoB_index,
    output logic [DP_PORTS*EX_ROB_WIDTH-1:0] RFDP_Qj,
    output logic [DP_PORTS*EX_ROB_WIDTH-1:0] RFDP_Qk,
    output logic [DP_PORTS*32-1:0]           RFDP_Vj,
    output logic [DP_PORTS*32-1:0]           RFDP_Vk,
    output logic                             RFDP_ready,
    input  logic                             RoBRF_flush,
    input  logic [CMT_PORTS-1:0]             RoBRF_en,
    input  logic [CMT_PORTS*EX_REG_WIDTH-1:0] RoBRF_rd,
    input  logic [CMT_PORTS*ROB_WIDTH-1:0]   RoBRF_RoB_index,
    input  logic [CMT_PORTS*32-1:0]          RoBRF_value
);

    rf_state_e                state;
    logic [31:0]              regs   [NUM_REGS];
    logic [31:0]              regs_n [NUM_REGS];
    logic [EX_ROB_WIDTH-1:0]  deps   [NUM_REGS];
    logic [EX_ROB_WIDTH-1:0]  deps_n [NUM_REGS];
    logic                     accept;
    logic                     flush_any;

    assign accept    = (state == RUN) && !RoBRF_flush;
    assign flush_any = RoBRF_flush || (state == FLUSH);

    // Commit first, then dispatch so a renaming lane overrides a clear.
    always_comb begin
        regs_n = regs;
        deps_n = deps;
        for (int c = 0; c < CMT_PORTS; c++) begin
            if (RoBRF_en[c] && is_reg(RoBRF_rd[c*EX_REG_WIDTH +: EX_REG_WIDTH])) begin
                regs_n[RoBRF_rd[c*EX_REG_WIDTH +: REG_WIDTH]] = RoBRF_value[c*32 +: 32];
                if (!RoBRF_flush &&
                    deps[RoBRF_rd[c*EX_REG_WIDTH +: REG_WIDTH]] ==
                    {1'b0, RoBRF_RoB_index[c*ROB_WIDTH +: ROB_WIDTH]}) begin
                    deps_n[RoBRF_rd[c*EX_REG_WIDTH +: REG_WIDTH]] = NON_DEP;
                end
            end
        end
        for (int j = 0; j < DP_PORTS; j++) begin
            if (accept && DPRF_en[j] &&
                is_reg(DPRF_rd[j*EX_REG_WIDTH +: EX_REG_WIDTH])) begin
                deps_n[DPRF_rd[j*EX_REG_WIDTH +: REG_WIDTH]] =
                    {1'b0, DPRF_RoB_index[j*ROB_WIDTH +: ROB_WIDTH]};
            end
        end
        if (RoBRF_flush) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                deps_n[i] = NON_DEP;
            end
        end
    end

    always_ff @(posedge Sys_clk or negedge Sys_rst_n) begin
        if (!Sys_rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
                deps[i] <= NON_DEP;
            end
        end else if (Sys_rdy) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= regs_n[i];
                deps[i] <= deps_n[i];
            end
        end
    end

    always_ff @(posedge Sys_clk or negedge Sys_rst_n) begin
        if (!Sys_rst_n) begin
            state      <= RUN;
            RFDP_ready <= 1'b1;
        end else if (Sys_rdy) begin
            unique case (state)
                RUN: begin
                    if (RoBRF_flush) begin
                        state      <= FLUSH;
                        RFDP_ready <= 1'b0;
                    end
                end
                FLUSH: begin
                    if (!RoBRF_flush) begin
                        state      <= RUN;
                        RFDP_ready <= 1'b1;
                    end
                end
                default: begin
                    state      <= RUN;
                    RFDP_ready <= 1'b1;
                end
            endcase
        end
    end

    for (genvar k = 0; k < DP_PORTS; k++) begin : g_lane
        rf_operand_lookup #(
            .K         (k),
            .DP_PORTS  (DP_PORTS),
            .CMT_PORTS (CMT_PORTS)
        ) u_rs1 (
            .rs        (DPRF_rs1[k*EX_REG_WIDTH +: EX_REG_WIDTH]),
            .flush_any (flush_any),
            .dp_en     (DPRF_en),
            .dp_rd     (DPRF_rd),
            .dp_index  (DPRF_RoB_index),
            .cmt_en    (RoBRF_en),
            .cmt_index (RoBRF_RoB_index),
            .cmt_value (RoBRF_value),
            .dep       (deps[DPRF_rs1[k*EX_REG_WIDTH +: REG_WIDTH]]),
            .reg_value (regs[DPRF_rs1[k*EX_REG_WIDTH +: REG_WIDTH]]),
            .q         (RFDP_Qj[k*EX_ROB_WIDTH +: EX_ROB_WIDTH]),
            .v         (RFDP_Vj[k*32 +: 32])
        );
        rf_operand_lookup #(
            .K         (k),
            .DP_PORTS  (DP_PORTS),
            .CMT_PORTS (CMT_PORTS)
        ) u_rs2 (
            .rs        (DPRF_rs2[k*EX_REG_WIDTH +: EX_REG_WIDTH]),
            .flush_any (flush_any),
            .dp_en     (DPRF_en),
            .dp_rd     (DPRF_rd),
            .dp_index  (DPRF_RoB_index),
            .cmt_en    (RoBRF_en),
            .cmt_index (RoBRF_RoB_index),
            .cmt_value (RoBRF_value),
            .dep       (deps[DPRF_rs2[k*EX_REG_WIDTH +: REG_WIDTH]]),
            .reg_value (regs[DPRF_rs2[k*EX_REG_WIDTH +: REG_WIDTH]]),
            .q         (RFDP_Qk[k*EX_ROB_WIDTH +: EX_ROB_WIDTH]),
            .v         (RFDP_Vk[k*32 +: 32])
        );
    end

endmodule

// File: tb/tb_register_file_mp.sv
// Randomized scoreboard bench for register_file_mp against a rename-table reference model.
module tb_register_file_mp;

    localparam int ND = 256;
    localparam int NR = 32;
`ifdef RF_ZERO_REG_EN
    localparam bit ZR = 1'b1;
`else
    localparam bit ZR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rdy;
    logic        flush;
    logic [1:0]  dp_en, cm_en;
    logic [11:0] dp_rs1, dp_rs2, dp_rd, cm_rd;
    logic [15:0] dp_idx, cm_idx;
    logic [63:0] cm_val;
    logic [17:0] qj, qk;
    logic [63:0] vj, vk;
    logic        ready;

    int d_en[2], d_rs1[2], d_rs2[2], d_rd[2], d_idx[2];
    int c_en[2], c_rd[2], c_idx[2], c_val[2];

    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            dp_en[k]          = d_en[k] != 0;
            dp_rs1[k*6 +: 6]  = 6'(d_rs1[k]);
            dp_rs2[k*6 +: 6]  = 6'(d_rs2[k]);
            dp_rd[k*6 +: 6]   = 6'(d_rd[k]);
            dp_idx[k*8 +: 8]  = 8'(d_idx[k]);
            cm_en[k]          = c_en[k] != 0;
            cm_rd[k*6 +: 6]   = 6'(c_rd[k]);
            cm_idx[k*8 +: 8]  = 8'(c_idx[k]);
            cm_val[k*32 +: 32] = 32'(c_val[k]);
        end
    end

    register_file_mp dut (
        .Sys_clk         (clk),
        .Sys_rst_n       (rst_n),
        .Sys_rdy         (rdy),
        .DPRF_en         (dp_en),
        .DPRF_rs1        (dp_rs1),
        .DPRF_rs2        (dp_rs2),
        .DPRF_rd         (dp_rd),
        .DPRF_RoB_index  (dp_idx),
        .RFDP_Qj         (qj),
        .RFDP_Qk         (qk),
        .RFDP_Vj         (vj),
        .RFDP_Vk         (vk),
        .RFDP_ready      (ready),
        .RoBRF_flush     (flush),
        .RoBRF_en        (cm_en),
        .RoBRF_rd        (cm_rd),
        .RoBRF_RoB_index (cm_idx),
        .RoBRF_value     (cm_val)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int qj_of(int k); return int'(qj[k*9 +: 9]); endfunction
    function automatic int qk_of(int k); return int'(qk[k*9 +: 9]); endfunction
    function automatic int vj_of(int k); return int'(vj[k*32 +: 32]); endfunction
    function automatic int vk_of(int k); return int'(vk[k*32 +: 32]); endfunction

    // Reference model: architectural values, rename tags, and a recovering flag.
    int m_reg[32];
    int m_dep[32];
    bit m_recover;

    function automatic bit writable(int r);
        return r != NR && !(ZR && r == 0);
    endfunction

    function automatic void ref_lookup(input int k, input int rs,
                                       output int q, output int v);
        bit done = 0;
        q = ND;
        v = 0;
        if (writable(rs)) begin
            for (int j = k - 1; j >= 0 && !done; j--) begin
                if (d_en[j] != 0 && d_rd[j] == rs) begin
                    q = d_idx[j];
                    done = 1;
                end
            end
            for (int c = 0; c < 2 && !done; c++) begin
                if (c_en[c] != 0 && m_dep[rs] == c_idx[c]) begin
                    v = c_val[c];
                    done = 1;
                end
            end
            if (!done) begin
                if (m_dep[rs] == ND) v = m_reg[rs];
                else q = m_dep[rs];
            end
        end
        if (flush || m_recover) q = ND;
    endfunction

    function automatic void model_step();
        int  nd[32];
        bit  acc;
        bit  renamed;
        if (!rdy) return;
        nd  = m_dep;
        acc = !m_recover && !flush;
        for (int c = 0; c < 2; c++) begin
            if (c_en[c] != 0 && writable(c_rd[c])) begin
                m_reg[c_rd[c]] = c_val[c];
                renamed = 0;
                for (int j = 0; j < 2; j++)
                    if (acc && d_en[j] != 0 && d_rd[j] == c_rd[c]) renamed = 1;
                if (!flush && !renamed && m_dep[c_rd[c]] == c_idx[c])
                    nd[c_rd[c]] = ND;
            end
        end
        for (int j = 0; j < 2; j++)
            if (acc && d_en[j] != 0 && writable(d_rd[j])) nd[d_rd[j]] = d_idx[j];
        if (flush)
            for (int i = 0; i < 32; i++) nd[i] = ND;
        m_dep = nd;
        m_recover = flush;
    endfunction

    typedef struct {
        int qj[2];
        int qk[2];
        int vj[2];
        int vk[2];
        int rdy;
    } exp_t;

    exp_t sb[$];

    task automatic eval();
        exp_t e;
        int   q, v;
        for (int k = 0; k < 2; k++) begin
            ref_lookup(k, d_rs1[k], q, v);
            e.qj[k] = q;
            e.vj[k] = v;
            ref_lookup(k, d_rs2[k], q, v);
            e.qk[k] = q;
            e.vk[k] = v;
        end
        e.rdy = m_recover ? 0 : 1;
        sb.push_back(e);
        model_step();
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("sb_qj%0d", k), qj_of(k), e.qj[k]);
                chk($sformatf("sb_qk%0d", k), qk_of(k), e.qk[k]);
                chk($sformatf("sb_vj%0d", k), vj_of(k), e.vj[k]);
                chk($sformatf("sb_vk%0d", k), vk_of(k), e.vk[k]);
            end
            chk("sb_ready", int'(ready), e.rdy);
        end
    end

    task automatic idle();
        rdy   = 1'b1;
        flush = 1'b0;
        for (int k = 0; k < 2; k++) begin
            d_en[k] = 0; d_rs1[k] = NR; d_rs2[k] = NR; d_rd[k] = NR; d_idx[k] = 0;
            c_en[k] = 0; c_rd[k] = NR; c_idx[k] = 0; c_val[k] = 0;
        end
    endtask

    task automatic nc();
        @(posedge clk);
        #1;
        idle();
    endtask

    function automatic int rnd_reg();
        int r = int'($urandom_range(0, 9));
        return (r > 7) ? NR : r;
    endfunction

    initial begin
        int ctr = 0;
        int r;
        for (int i = 0; i < 32; i++) begin
            m_reg[i] = 0;
            m_dep[i] = ND;
        end
        m_recover = 0;
        rst_n = 1'b0;
        idle();
        d_en[0] = 1; d_rs1[0] = 3;
        @(negedge clk);
        chk("rst_ready", int'(ready), 1);
        chk("rst_qj", qj_of(0), ND);
        chk("rst_vj", vj_of(0), 0);

        nc(); rst_n = 1'b1;
        d_en[0] = 1; d_rs1[0] = 3; eval();
        chk("t1_qj", qj_of(0), ND);
        chk("t1_vj", vj_of(0), 0);
        chk("t1_ready", int'(ready), 1);

        nc(); d_en[0] = 1; d_rd[0] = 5; d_idx[0] = 7; eval();
        nc(); d_en[0] = 1; d_rs1[0] = 5; eval();
        chk("dep5_qj", qj_of(0), 7);
        nc(); d_rs1[0] = 5; c_en[0] = 1; c_rd[0] = 5; c_idx[0] = 7; c_val[0] = 'hAB; eval();
        chk("cfwd_qj", qj_of(0), ND);
        chk("cfwd_vj", vj_of(0), 'hAB);
        nc(); d_rs1[0] = 5; eval();
        chk("reg5_vj", vj_of(0), 'hAB);

        nc(); d_en[0] = 1; d_rd[0] = 4; d_idx[0] = 9;
        d_en[1] = 1; d_rs2[1] = 4; eval();
        chk("intra_qk1", qk_of(1), 9);
        nc(); d_rs1[0] = 4; eval();
        chk("dep4_qj", qj_of(0), 9);

        nc(); d_en[0] = 1; d_rd[0] = 6; d_idx[0] = 10;
        d_en[1] = 1; d_rd[1] = 6; d_idx[1] = 11; eval();
        nc(); c_en[0] = 1; c_rd[0] = 2; c_idx[0] = 100; c_val[0] = 1;
        c_en[1] = 1; c_rd[1] = 2; c_idx[1] = 101; c_val[1] = 2; eval();
        nc(); d_rs1[0] = 6; d_rs2[0] = 2; eval();
        chk("dep6_qj", qj_of(0), 11);
        chk("reg2_vk", vk_of(0), 2);

        nc(); d_en[0] = 1; d_rd[0] = 8; d_idx[0] = 3; eval();
        nc(); c_en[0] = 1; c_rd[0] = 8; c_idx[0] = 3; c_val[0] = 'h55;
        d_en[0] = 1; d_rd[0] = 8; d_idx[0] = 12; eval();
        nc(); d_rs1[0] = 8; eval();
        chk("coll_qj", qj_of(0), 12);

        nc(); d_en[0] = 1; d_rd[0] = 1; d_idx[0] = 20; eval();
        nc(); flush = 1; c_en[0] = 1; c_rd[0] = 9; c_idx[0] = 150; c_val[0] = 5;
        d_rs1[0] = 1; d_rs2[0] = 8; eval();
        chk("fl_qj", qj_of(0), ND);
        chk("fl_qk", qk_of(0), ND);
        nc(); d_en[0] = 1; d_rd[0] = 1; d_idx[0] = 30; d_rs1[1] = 1; eval();
        chk("fl_ready0", int'(ready), 0);
        nc(); d_rs1[0] = 1; d_rs2[0] = 9; d_rs1[1] = 8; eval();
        chk("fl_ready1", int'(ready), 1);
        chk("fl_dep1_q", qj_of(0), ND);
        chk("fl_reg9", vk_of(0), 5);
        chk("fl_reg8", vj_of(1), 'h55);

        nc(); c_en[0] = 1; c_rd[0] = 0; c_idx[0] = 201; c_val[0] = 7; eval();
        nc(); d_rs1[0] = 0; eval();
        chk("r0_q", qj_of(0), ND);
        chk("r0_v", vj_of(0), ZR ? 0 : 7);

        for (int it = 0; it < 600; it++) begin
            nc();
            rdy   = $urandom_range(0, 9) != 0;
            flush = $urandom_range(0, 19) == 0;
            for (int k = 0; k < 2; k++) begin
                d_en[k]  = int'($urandom_range(0, 1));
                d_rs1[k] = rnd_reg();
                d_rs2[k] = rnd_reg();
                d_rd[k]  = rnd_reg();
                d_idx[k] = (ctr + k) % 256;
            end
            ctr = (ctr + 2) % 256;
            for (int c = 0; c < 2; c++) begin
                r = rnd_reg();
                c_en[c] = int'($urandom_range(0, 1));
                c_rd[c] = r;
                if (r != NR && m_dep[r] != ND && $urandom_range(0, 3) != 0)
                    c_idx[c] = m_dep[r];
                else
                    c_idx[c] = int'($urandom_range(0, 255));
                c_val[c] = int'($urandom);
            end
            if (c_idx[1] == c_idx[0]) c_en[1] = 0;
            eval();
        end

        nc();
        chk("sb_drain", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
